// File: rtl/compare_timer_ctrl.sv
// Prescaled 32-bit compare timer with memory-mapped COUNT/CTRL/STATUS and a level IRQ.
// Read data is registered one cycle after the strobe; no backpressure, a strobe is accepted every cycle.
module compare_timer_ctrl #(
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS_N,
    input  logic        WR_N,
    input  logic        RD_N,
    input  logic [11:0] Addr,
    input  logic [31:0] DataIn,
    input  logic [31:0] CompareR,
    output logic [31:0] DataOut,
    output logic [31:0] Count,
    output logic        IRQ
);
    localparam logic [11:0] ADDR_COUNT  = 12'h004;
    localparam logic [11:0] ADDR_CTRL   = 12'h008;
    localparam logic [11:0] ADDR_STATUS = 12'h00C;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          count_q, count_d;
    logic                 en_q, en_d;
    logic                 ar_q, ar_d;
    logic                 ie_q, ie_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PRESC_W-1:0]   pre_q, pre_d;
    logic                 match_q, match_d;
    logic                 ovf_q, ovf_d;
    logic                 irq_q, irq_d;
    logic [31:0]          data_out_q, data_out_d;

    logic        wr_en, rd_en;
    logic        wr_count, wr_ctrl, wr_status;
    logic        tick, set_match, set_ovf;
    logic [31:0] rdata;

    assign wr_en     = ~CS_N & ~WR_N;
    assign rd_en     = ~CS_N & ~RD_N;
    assign wr_count  = wr_en && (Addr == ADDR_COUNT);
    assign wr_ctrl   = wr_en && (Addr == ADDR_CTRL);
    assign wr_status = wr_en && (Addr == ADDR_STATUS);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        en_d      = en_q;
        ar_d      = ar_q;
        ie_d      = ie_q;
        presc_d   = presc_q;
        pre_d     = '0;
        tick      = 1'b0;
        set_match = 1'b0;
        set_ovf   = 1'b0;

        if (wr_ctrl) begin
            en_d    = DataIn[0];
            ar_d    = DataIn[1];
            ie_d    = DataIn[2];
            presc_d = DataIn[8 +: PRESC_W];
        end

        case (state_q)
            ST_STOP: begin
                if (wr_ctrl && DataIn[0]) state_d = ST_RUN;
            end
            ST_RUN: begin
                tick  = (pre_q == presc_q);
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (wr_ctrl && !DataIn[0]) begin
                    state_d = ST_STOP;
                end else if (tick && !wr_count) begin
                    // Match is tested before increment, so a match at all-ones never overflows.
                    if (count_q == CompareR) begin
                        set_match = 1'b1;
                        if (ar_q) count_d = '0;
                        else      state_d = ST_HALT;
                    end else begin
                        count_d = count_q + 32'd1;
                        set_ovf = &count_q;
                    end
                end
            end
            ST_HALT: begin
                if (wr_ctrl && !DataIn[0])   state_d = ST_STOP;
                else if (wr_count && en_q)   state_d = ST_RUN;
            end
            default: state_d = ST_STOP;
        endcase

        // Prescaler only runs while staying in RUN; any (re)entry starts from 0.
        if (state_d != ST_RUN) pre_d = '0;

        if (wr_count) count_d = DataIn;

        match_d = (match_q & ~(wr_status & DataIn[0])) | set_match;
        ovf_d   = (ovf_q   & ~(wr_status & DataIn[1])) | set_ovf;
        irq_d   = ie_q & (match_q | ovf_q);

        rdata = '0;
        case (Addr)
            ADDR_COUNT:  rdata = count_q;
            ADDR_CTRL: begin
                rdata[0]            = en_q;
                rdata[1]            = ar_q;
                rdata[2]            = ie_q;
                rdata[8 +: PRESC_W] = presc_q;
            end
            ADDR_STATUS: rdata = {30'd0, ovf_q, match_q};
            default:     rdata = '0;
        endcase
        data_out_d = rd_en ? rdata : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_STOP;
            count_q    <= '0;
            en_q       <= 1'b0;
            ar_q       <= 1'b0;
            ie_q       <= 1'b0;
            presc_q    <= '0;
            pre_q      <= '0;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            en_q       <= en_d;
            ar_q       <= ar_d;
            ie_q       <= ie_d;
            presc_q    <= presc_d;
            pre_q      <= pre_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            data_out_q <= data_out_d;
        end
    end

    assign DataOut = data_out_q;
    assign Count   = count_q;
    assign IRQ     = irq_q;
endmodule

// File: tb/tb_compare_timer_ctrl.sv
// Bench for compare_timer_ctrl: register-map vector table plus hand-written timer sequences.
module tb_compare_timer_ctrl;
    localparam logic [11:0] A_COUNT  = 12'h004;
    localparam logic [11:0] A_CTRL   = 12'h008;
    localparam logic [11:0] A_STATUS = 12'h00C;

    logic        clk = 1'b0;
    logic        reset;
    logic        CS_N, WR_N, RD_N;
    logic [11:0] Addr;
    logic [31:0] DataIn, CompareR, DataOut, Count;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          is_rd;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[11];

    compare_timer_ctrl #(.PRESC_W(8)) dut (
        .clk(clk), .reset(reset), .CS_N(CS_N), .WR_N(WR_N), .RD_N(RD_N),
        .Addr(Addr), .DataIn(DataIn), .CompareR(CompareR),
        .DataOut(DataOut), .Count(Count), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        CS_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1;
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
        CS_N = 1'b0; WR_N = 1'b0; RD_N = 1'b1; Addr = a; DataIn = d;
        step();
        idle();
    endtask

    task automatic bus_rd(input string name, input logic [11:0] a, input logic [31:0] e);
        CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b1; Addr = a;
        exp_q.push_back(e);
        step();
        idle();
        chk(name, DataOut, exp_q.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, A_CTRL,   32'hFFFF_FFF6, 32'h0};
        tbl[1]  = '{1'b1, A_CTRL,   32'h0,         32'h0000_FF06};
        tbl[2]  = '{1'b0, A_COUNT,  32'h1234_5678, 32'h0};
        tbl[3]  = '{1'b1, A_COUNT,  32'h0,         32'h1234_5678};
        tbl[4]  = '{1'b0, 12'h010,  32'hDEAD_BEEF, 32'h0};
        tbl[5]  = '{1'b1, 12'h010,  32'h0,         32'h0};
        tbl[6]  = '{1'b1, 12'h000,  32'h0,         32'h0};
        tbl[7]  = '{1'b0, A_STATUS, 32'h3,         32'h0};
        tbl[8]  = '{1'b1, A_STATUS, 32'h0,         32'h0};
        tbl[9]  = '{1'b0, A_CTRL,   32'h0,         32'h0};
        tbl[10] = '{1'b1, A_CTRL,   32'h0,         32'h0};

        reset = 1'b1; idle(); Addr = '0; DataIn = '0; CompareR = 32'hFFFF_FFFF;
        step(); step();
        chk("rst_count", Count, 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        chk("rst_dataout", DataOut, 32'h0);
        reset = 1'b0;
        bus_rd("rst_ctrl", A_CTRL, 32'h0);
        bus_rd("rst_count_rd", A_COUNT, 32'h0);
        bus_rd("rst_status", A_STATUS, 32'h0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].is_rd) bus_rd($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
            else              bus_wr(tbl[i].addr, tbl[i].data);
        end

        bus_wr(A_COUNT, 32'hA5A5_0001);
        bus_rd("hold_rd", A_COUNT, 32'hA5A5_0001);
        step(); step();
        chk("hold_dataout", DataOut, 32'hA5A5_0001);
        bus_wr(A_COUNT, 32'h0);

        // One-shot compare: count to 5, halt, IRQ one cycle after MATCH.
        CompareR = 32'd5;
        bus_wr(A_CTRL, 32'h5);
        chk("t2_start", Count, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("t2_cnt%0d", i), Count, 32'(i));
        end
        step();
        chk("t2_halt_cnt", Count, 32'd5);
        chk("t2_irq_lag", 32'(IRQ), 32'h0);
        step();
        chk("t2_irq_set", 32'(IRQ), 32'h1);
        bus_rd("t2_status", A_STATUS, 32'h1);
        bus_wr(A_STATUS, 32'h1);
        chk("t2_irq_after_w1c", 32'(IRQ), 32'h1);
        step();
        chk("t2_irq_clr", 32'(IRQ), 32'h0);
        bus_rd("t2_status_clr", A_STATUS, 32'h0);
        repeat (4) step();
        chk("t2_still_halt", Count, 32'd5);
        bus_wr(A_CTRL, 32'h0);

        // Auto-reload with PRESC=2: one increment every 3 cycles, wrap after 3.
        CompareR = 32'd3;
        bus_wr(A_COUNT, 32'h0);
        bus_wr(A_CTRL, 32'h0000_0203);
        for (int c = 1; c <= 13; c++) begin
            step();
            chk($sformatf("t3_c%0d", c), Count, 32'((c / 3) % 4));
        end
        bus_rd("t3_match1", A_STATUS, 32'h1);
        bus_wr(A_STATUS, 32'h1);
        for (int c = 16; c <= 25; c++) begin
            step();
            chk($sformatf("t3_c%0d", c), Count, 32'((c / 3) % 4));
        end
        bus_rd("t3_match2", A_STATUS, 32'h1);
        chk("t3_irq_off", 32'(IRQ), 32'h0);
        bus_wr(A_CTRL, 32'h0);

        // Compare at all-ones: match fires first, no overflow.
        bus_wr(A_STATUS, 32'h3);
        CompareR = 32'hFFFF_FFFF;
        bus_wr(A_COUNT, 32'hFFFF_FFFE);
        bus_wr(A_CTRL, 32'h7);
        chk("t4_start", Count, 32'hFFFF_FFFE);
        step();
        chk("t4_max", Count, 32'hFFFF_FFFF);
        step();
        chk("t4_reload", Count, 32'h0);
        bus_rd("t4_no_ovf", A_STATUS, 32'h1);
        bus_wr(A_CTRL, 32'h0);

        // Genuine overflow: wrap without match.
        bus_wr(A_STATUS, 32'h3);
        CompareR = 32'd10;
        bus_wr(A_COUNT, 32'hFFFF_FFFF);
        bus_wr(A_CTRL, 32'h5);
        step();
        chk("ovf_wrap", Count, 32'h0);
        chk("ovf_irq_lag", 32'(IRQ), 32'h0);
        step();
        chk("ovf_irq", 32'(IRQ), 32'h1);
        chk("ovf_cnt1", Count, 32'h1);
        bus_rd("ovf_status", A_STATUS, 32'h2);

        // COUNT write coincides with a tick (PRESC=0): the write wins.
        bus_wr(A_COUNT, 32'h10);
        chk("t5_wr_wins", Count, 32'h10);
        step();
        chk("t5_after_wr", Count, 32'h11);

        // W1C in the same cycle as a new match: set wins.
        bus_wr(A_CTRL, 32'h0);
        bus_wr(A_STATUS, 32'h3);
        CompareR = 32'h20;
        bus_wr(A_COUNT, 32'h1E);
        bus_wr(A_CTRL, 32'h3);
        step();
        step();
        chk("t5_at_cmp", Count, 32'h20);
        bus_wr(A_STATUS, 32'h1);
        chk("t5_reloaded", Count, 32'h0);
        bus_rd("t5_set_wins", A_STATUS, 32'h1);

        // Reset while running with IRQ high and a read in flight.
        bus_wr(A_CTRL, 32'h7);
        step();
        chk("t6_irq_pre", 32'(IRQ), 32'h1);
        reset = 1'b1;
        CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b1; Addr = A_COUNT;
        step();
        idle();
        chk("t6_count", Count, 32'h0);
        chk("t6_irq", 32'(IRQ), 32'h0);
        chk("t6_dataout", DataOut, 32'h0);
        reset = 1'b0;
        repeat (3) step();
        chk("t6_stopped", Count, 32'h0);
        bus_rd("t6_ctrl", A_CTRL, 32'h0);
        bus_rd("t6_status", A_STATUS, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
